route_merge: RTL

Egress-side collector for the two-lane router. It drains the two 6x8 output FIFOs by driving their `read` strobes, arbitrating round-robin between lanes. It tags each popped byte with its lane ID and presents a single 10-bit stream with valid/pause flow control. A 2-entry skid buffer absorbs the FIFOs' one-cycle read latency, so downstream pause never loses data.

---
 rtl/route_merge.sv | 99 +++++++++
 1 files changed

// File: rtl/route_merge.sv
// route_merge: round-robin drain of two lane FIFOs into one tagged stream,
// with a 2-entry skid buffer covering the FIFOs' one-cycle read latency.
module route_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  fifo0_empty,
    input  logic                  fifo1_empty,
    input  logic                  out_pause,
    output logic                  read0,
    output logic                  read1,
    output logic [DATA_WIDTH+1:0] out,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  count0,
    output logic [CNT_WIDTH-1:0]  count1,
    output logic                  idle
);
    typedef enum logic [1:0] {RD_NONE, RD0, RD1} state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [DATA_WIDTH+1:0] head_q, head_d, tail_q, tail_d;
    logic                  head_v_q, head_v_d, tail_v_q, tail_v_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                  el0, el1, gnt0, gnt1, rd_en, drain, inflight, adv;
    logic [1:0]            load;
    logic [DATA_WIDTH+1:0] cap_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RD_NONE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // A lane granted last cycle sits out one cycle so its empty flag can settle.
    always_comb begin
        inflight = state_q != RD_NONE;
        drain    = head_v_q & ~out_pause;
        load     = {1'b0, head_v_q} + {1'b0, tail_v_q} + {1'b0, inflight};
        rd_en    = reset & ~out_pause & (load < 2'd2 + {1'b0, drain});
        el0      = ~fifo0_empty & (state_q != RD0);
        el1      = ~fifo1_empty & (state_q != RD1);
        gnt1     = rd_en & el1 & (~el0 | rr_q);
        gnt0     = rd_en & el0 & ~gnt1;
        state_d  = gnt0 ? RD0 : gnt1 ? RD1 : RD_NONE;
        rr_d     = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
    end

    always_comb begin
        read0 = gnt0;
        read1 = gnt1;
    end

    // The head slot frees when empty or draining; the tail moves up, and the capture fills behind it.
    always_comb begin
        cap_w    = {1'b0, state_q == RD1, (state_q == RD1) ? in1 : in0};
        adv      = ~head_v_q | drain;
        head_v_d = adv ? (tail_v_q | inflight) : 1'b1;
        head_d   = adv ? (tail_v_q ? tail_q : inflight ? cap_w : head_q) : head_q;
        tail_v_d = adv ? (tail_v_q & inflight) : (tail_v_q | inflight);
        tail_d   = (inflight & (~adv | tail_v_q)) ? cap_w : tail_q;
        cnt0_d   = cnt0_q + {{(CNT_WIDTH-1){1'b0}}, drain & ~head_q[DATA_WIDTH]};
        cnt1_d   = cnt1_q + {{(CNT_WIDTH-1){1'b0}}, drain & head_q[DATA_WIDTH]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            head_v_q <= head_v_d;
            tail_v_q <= tail_v_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    always_comb begin
        out       = head_q;
        out_valid = head_v_q;
        count0    = cnt0_q;
        count1    = cnt1_q;
        idle      = ~head_v_q & ~tail_v_q & ~inflight & fifo0_empty & fifo1_empty;
    end
endmodule
